// File: rtl/fpnew_pkg.sv
// Shared FP definitions used by the cast result buffer: formats, IEEE status flags, widths.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 32;
        endcase
    endfunction

endpackage

// File: rtl/fpnew_cast_result_buffer.sv
// Result FIFO behind the int-to-float cast unit: NaN-boxes results to Flen at write time and,
// with FPNEW_CAST_FFLAGS_ACCUM_EN defined, accumulates sticky IEEE flags on each pop.
module fpnew_cast_result_buffer
    import fpnew_pkg::*;
#(
    parameter fp_format_e  DstFpFormat = FP32,
    parameter int unsigned Flen        = 64,
    parameter int unsigned Depth       = 2,
    parameter type         TagType     = logic,
    localparam int unsigned DST_WIDTH  = fp_width(DstFpFormat)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DST_WIDTH-1:0] result_i,
    input  status_t              status_i,
    input  logic                 extension_bit_i,
    input  TagType               tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [Flen-1:0]      result_o,
    output status_t              status_o,
    output TagType               tag_o,
    input  logic                 fflags_clr_i,
    output status_t              fflags_o,
    output logic                 busy_o
);

    localparam int unsigned CNT_W = $clog2(Depth + 1);
    localparam int unsigned PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(Depth);
    localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(Depth - 1);

    typedef struct packed {
        status_t         status;
        TagType          tag;
        logic [Flen-1:0] result;
    } entry_t;

    entry_t           mem [Depth];
    entry_t           head;
    entry_t           last_q;
    entry_t           wr_entry;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [Flen-1:0]  boxed;
    logic             push, pop;

    if (Flen == DST_WIDTH) begin : g_no_box
        logic ext_unused;
        assign ext_unused = extension_bit_i;
        assign boxed      = result_i;
    end else begin : g_box
        assign boxed = {{(Flen - DST_WIDTH){extension_bit_i}}, result_i};
    end

    assign in_ready_o  = (cnt != FULL);
    assign out_valid_o = (cnt != '0);
    assign busy_o      = out_valid_o;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    assign wr_entry = '{status: status_i, tag: tag_i, result: boxed};
    assign head     = mem[rd_ptr];

    // When empty the outputs keep showing the most recently presented head entry.
    assign result_o = out_valid_o ? head.result : last_q.result;
    assign status_o = out_valid_o ? head.status : last_q.status;
    assign tag_o    = out_valid_o ? head.tag    : last_q.tag;

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            if (out_valid_o) last_q <= head;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_IX) ? '0 : wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IX) ? '0 : rd_ptr + 1'b1;
                last_q <= head;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef FPNEW_CAST_FFLAGS_ACCUM_EN
    status_t fflags_q;
    logic    pop_acc;

    // A flushed head is discarded, not consumed, so it contributes no flags.
    assign pop_acc = pop & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)             fflags_q <= '0;
        else if (fflags_clr_i) fflags_q <= pop_acc ? status_o : '0;
        else if (pop_acc)      fflags_q <= fflags_q | status_o;
    end

    assign fflags_o = fflags_q;
`else
    logic fflags_clr_unused;
    assign fflags_clr_unused = fflags_clr_i;
    assign fflags_o          = '0;
`endif

endmodule

// File: tb/tb_fpnew_cast_result_buffer.sv
// Directed bench for fpnew_cast_result_buffer (FP32 -> Flen 64, Depth 2).
module tb_fpnew_cast_result_buffer;
    import fpnew_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i, in_valid_i, in_ready_o;
    logic [31:0] result_i;
    status_t     status_i;
    logic        extension_bit_i, tag_i;
    logic        out_valid_o, out_ready_i;
    logic [63:0] result_o;
    status_t     status_o;
    logic        tag_o;
    logic        fflags_clr_i;
    status_t     fflags_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    fpnew_cast_result_buffer #(
        .DstFpFormat(FP32), .Flen(64), .Depth(2), .TagType(logic)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .result_i(result_i), .status_i(status_i), .extension_bit_i(extension_bit_i),
        .tag_i(tag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
        .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] st,
                         input logic ext, input logic tg);
        in_valid_i      = v;
        result_i        = r;
        status_i        = st;
        extension_bit_i = ext;
        tag_i           = tg;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; fflags_clr_i = 1'b0;
        drive(1'b0, 32'h0, 5'b0, 1'b0, 1'b0);
        step(); step();
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0 || fflags_o !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%b rdy=%b busy=%b ff=%b want v=0 rdy=1 busy=0 ff=00000",
                     out_valid_o, in_ready_o, busy_o, fflags_o);
        end
        checks++;
        if (result_o !== 64'h0 || status_o !== 5'b0 || tag_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got r=%h s=%b t=%b want zeros", result_o, status_o, tag_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_boxing();
        drive(1'b1, 32'h3F800000, 5'b0, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 64'hFFFFFFFF_3F800000 || tag_o !== 1'b1) begin
            errors++;
            $display("FAIL box_ext1: got v=%b r=%h t=%b want v=1 r=ffffffff3f800000 t=1",
                     out_valid_o, result_o, tag_o);
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 64'hFFFFFFFF_3F800000) begin
            errors++;
            $display("FAIL empty_hold: got v=%b busy=%b r=%h want v=0 busy=0 r=ffffffff3f800000",
                     out_valid_o, busy_o, result_o);
        end
        drive(1'b1, 32'h3F800000, 5'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 5'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 64'h00000000_3F800000) begin
            errors++;
            $display("FAIL box_ext0: got v=%b r=%h want v=1 r=000000003f800000", out_valid_o, result_o);
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
    endtask

    // A (NX), B (NV), C (OF); C must be held off until A pops.
    task automatic test_full_order();
        drive(1'b1, 32'h40000000, 5'b00001, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h40400000, 5'b10000, 1'b1, 1'b1);
        step();
        checks++;
        if (in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL full_ready: got rdy=%b busy=%b want rdy=0 busy=1", in_ready_o, busy_o);
        end
        drive(1'b1, 32'h40800000, 5'b00100, 1'b1, 1'b0);
        step();
        checks++;
        if (in_ready_o !== 1'b0 || result_o !== 64'hFFFFFFFF_40000000 || status_o !== 5'b00001) begin
            errors++;
            $display("FAIL full_hold: got rdy=%b r=%h s=%b want rdy=0 r=ffffffff40000000 s=00001",
                     in_ready_o, result_o, status_o);
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checks++;
        if (result_o !== 64'hFFFFFFFF_40400000 || tag_o !== 1'b1 || in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL pop_a: got r=%h t=%b rdy=%b want r=ffffffff40400000 t=1 rdy=1",
                     result_o, tag_o, in_ready_o);
        end
        step();
        drive(1'b0, 32'h0, 5'b0, 1'b0, 1'b0);
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL c_pushed: got rdy=%b want rdy=0", in_ready_o);
        end
        out_ready_i = 1'b1;
        step();
        checks++;
        if (result_o !== 64'hFFFFFFFF_40800000 || status_o !== 5'b00100) begin
            errors++;
            $display("FAIL pop_b: got r=%h s=%b want r=ffffffff40800000 s=00100", result_o, status_o);
        end
`ifdef FPNEW_CAST_FFLAGS_ACCUM_EN
        checks++;
        if (fflags_o !== 5'b10001) begin
            errors++;
            $display("FAIL fflags_accum: got %b want 10001", fflags_o);
        end
        fflags_clr_i = 1'b1;
`endif
        step();
        fflags_clr_i = 1'b0;
        out_ready_i  = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL pop_c: got v=%b want v=0", out_valid_o);
        end
`ifdef FPNEW_CAST_FFLAGS_ACCUM_EN
        checks++;
        if (fflags_o !== 5'b00100) begin
            errors++;
            $display("FAIL fflags_clr_pop: got %b want 00100", fflags_o);
        end
`else
        checks++;
        if (fflags_o !== 5'b00000) begin
            errors++;
            $display("FAIL fflags_off: got %b want 00000", fflags_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h41000000, 5'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h41100000, 5'b0, 1'b0, 1'b1);
        out_ready_i = 1'b1;
        step();
        drive(1'b0, 32'h0, 5'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid_o !== 1'b1 || busy_o !== 1'b1 || in_ready_o !== 1'b1 ||
            result_o !== 64'h00000000_41100000 || tag_o !== 1'b1) begin
            errors++;
            $display("FAIL push_pop: got v=%b busy=%b rdy=%b r=%h t=%b want 1 1 1 0000000041100000 1",
                     out_valid_o, busy_o, in_ready_o, result_o, tag_o);
        end
        step();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_drain: got v=%b want v=0", out_valid_o);
        end
    endtask

    task automatic test_flush();
        logic [4:0] ff_before;
        ff_before = fflags_o;
        drive(1'b1, 32'h42000000, 5'b01000, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h42100000, 5'b00010, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'h42200000, 5'b00001, 1'b1, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 5'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0 || fflags_o !== ff_before) begin
            errors++;
            $display("FAIL flush: got v=%b rdy=%b busy=%b ff=%b want v=0 rdy=1 busy=0 ff=%b",
                     out_valid_o, in_ready_o, busy_o, fflags_o, ff_before);
        end
        checks++;
        if (result_o !== 64'hFFFFFFFF_42000000) begin
            errors++;
            $display("FAIL flush_hold: got r=%h want ffffffff42000000", result_o);
        end
        drive(1'b1, 32'h43000000, 5'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 64'h00000000_43000000 || tag_o !== 1'b1) begin
            errors++;
            $display("FAIL post_flush: got v=%b r=%h t=%b want v=1 r=0000000043000000 t=1",
                     out_valid_o, result_o, tag_o);
        end
`ifdef FPNEW_CAST_FFLAGS_ACCUM_EN
        fflags_clr_i = 1'b1;
        step();
        fflags_clr_i = 1'b0;
        checks++;
        if (fflags_o !== 5'b00000) begin
            errors++;
            $display("FAIL fflags_clr: got %b want 00000", fflags_o);
        end
`endif
    endtask

    task automatic test_async_reset();
        #3 rst_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || result_o !== 64'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b rdy=%b r=%h want v=0 rdy=1 r=0",
                     out_valid_o, in_ready_o, result_o);
        end
        step();
        rst_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_boxing();
        test_full_order();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
